// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display family.
// Holds the active-high 7-segment patterns, bit order {g,f,e,d,c,b,a},
// and the legal upper limit of each time field.
package stopwatch_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Field range limits: centiseconds/hours 0-99, seconds/minutes 0-59.
  localparam int LIM_99 = 99;
  localparam int LIM_59 = 59;

endpackage

// File: rtl/stopwatch_display_bin2bcd_99.sv
// Combinational binary to two-digit decimal split for one time field.
// Ports:
//   v    - 8-bit binary field value
//   tens - v / 10 (zero when out of range)
//   ones - v mod 10 (zero when out of range)
//   oor  - high when v exceeds LIMIT
module bin2bcd_99 #(
  parameter int LIMIT = 99
) (
  input  logic [7:0] v,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       oor
);

  always_comb begin
    oor  = (v > 8'(LIMIT));
    tens = '0;
    ones = '0;
    if (!oor) begin
      tens = 4'(v / 8'd10);
      ones = 4'(v % 8'd10);
    end
  end

endmodule

// File: rtl/stopwatch_display.sv
// Eight-digit multiplexed 7-segment driver for an hh.mm.ss.xx stopwatch.
// Ports:
//   clk            - system clock
//   rst            - synchronous active-high reset
//   xx, ss, mm, hh - binary time fields (centiseconds, seconds, minutes, hours)
//   seg            - registered segment drive {dp,g,f,e,d,c,b,a}, active-high
//   an             - registered one-hot digit enable, an[0] = rightmost digit
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] xx,
  input  logic [7:0] ss,
  input  logic [7:0] mm,
  input  logic [7:0] hh,
  output logic [7:0] seg,
  output logic [7:0] an
);

  localparam int DIV = CLK_HZ / (SCAN_HZ * 8);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] presc_p0;
  logic [2:0]    idx_p0;
  logic          vld_p0;
  logic [7:0]    snap_xx_p0, snap_ss_p0, snap_mm_p0, snap_hh_p0;
  logic          tick;

  logic [3:0] xx_tens, xx_ones, ss_tens, ss_ones;
  logic [3:0] mm_tens, mm_ones, hh_tens, hh_ones;
  logic       xx_oor, ss_oor, mm_oor, hh_oor;
  logic [3:0] digit;
  logic       dash;
  logic       dp;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = SEG_0;
      4'd1:    seg7 = SEG_1;
      4'd2:    seg7 = SEG_2;
      4'd3:    seg7 = SEG_3;
      4'd4:    seg7 = SEG_4;
      4'd5:    seg7 = SEG_5;
      4'd6:    seg7 = SEG_6;
      4'd7:    seg7 = SEG_7;
      4'd8:    seg7 = SEG_8;
      4'd9:    seg7 = SEG_9;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  assign tick = (presc_p0 == PW'(DIV - 1));

  bin2bcd_99 #(.LIMIT(LIM_99)) u_xx (.v(snap_xx_p0), .tens(xx_tens), .ones(xx_ones), .oor(xx_oor));
  bin2bcd_99 #(.LIMIT(LIM_59)) u_ss (.v(snap_ss_p0), .tens(ss_tens), .ones(ss_ones), .oor(ss_oor));
  bin2bcd_99 #(.LIMIT(LIM_59)) u_mm (.v(snap_mm_p0), .tens(mm_tens), .ones(mm_ones), .oor(mm_oor));
  bin2bcd_99 #(.LIMIT(LIM_99)) u_hh (.v(snap_hh_p0), .tens(hh_tens), .ones(hh_ones), .oor(hh_oor));

  // Stage p0 -> p1: pick the digit for the current index from the snapshot.
  always_comb begin
    digit = '0;
    dash  = 1'b0;
    case (idx_p0)
      3'd0: begin digit = xx_ones; dash = xx_oor; end
      3'd1: begin digit = xx_tens; dash = xx_oor; end
      3'd2: begin digit = ss_ones; dash = ss_oor; end
      3'd3: begin digit = ss_tens; dash = ss_oor; end
      3'd4: begin digit = mm_ones; dash = mm_oor; end
      3'd5: begin digit = mm_tens; dash = mm_oor; end
      3'd6: begin digit = hh_ones; dash = hh_oor; end
      3'd7: begin digit = hh_tens; dash = hh_oor; end
      default: begin digit = '0; dash = 1'b0; end
    endcase
    dp = (idx_p0 == 3'd2) || (idx_p0 == 3'd4) || (idx_p0 == 3'd6);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_p0   <= '0;
      idx_p0     <= 3'd7;
      vld_p0     <= 1'b0;
      snap_xx_p0 <= '0;
      snap_ss_p0 <= '0;
      snap_mm_p0 <= '0;
      snap_hh_p0 <= '0;
      an         <= 8'h00;
      seg        <= 8'h00;
    end else begin
      // Stage p0: prescaler, digit index, frame snapshot on the 7 -> 0 wrap.
      presc_p0 <= tick ? '0 : presc_p0 + 1'b1;
      vld_p0   <= tick;
      if (tick) begin
        idx_p0 <= idx_p0 + 3'd1;
        if (idx_p0 == 3'd7) begin
          snap_xx_p0 <= xx;
          snap_ss_p0 <= ss;
          snap_mm_p0 <= mm;
          snap_hh_p0 <= hh;
        end
      end
      // Stage p1: registered display outputs, one cycle after the tick.
      if (vld_p0) begin
        an  <= 8'h01 << idx_p0;
        seg <= {dp, dash ? SEG_DASH : seg7(digit)};
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Scoreboard bench for stopwatch_display (CLK_HZ=800, SCAN_HZ=10 -> DIV=10).
// Expected frames are written as 32-bit hex words read like the display:
// nibble 7 is the leftmost digit (hh tens), nibble 0 the rightmost (xx ones),
// nibble value 4'hA stands for a dash.
module tb_stopwatch_display;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] xx = 8'd0, ss = 8'd0, mm = 8'd0, hh = 8'd0;
  logic [7:0] seg, an;

  int total = 0;
  int bad   = 0;
  logic [15:0] q[$];
  logic [7:0]  last_an = 8'h00;

  stopwatch_display #(.CLK_HZ(800), .SCAN_HZ(10)) dut (
    .clk(clk), .rst(rst), .xx(xx), .ss(ss), .mm(mm), .hh(hh),
    .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'h0: enc = 7'b0111111;
      4'h1: enc = 7'b0000110;
      4'h2: enc = 7'b1011011;
      4'h3: enc = 7'b1001111;
      4'h4: enc = 7'b1100110;
      4'h5: enc = 7'b1101101;
      4'h6: enc = 7'b1111101;
      4'h7: enc = 7'b0000111;
      4'h8: enc = 7'b1111111;
      4'h9: enc = 7'b1101111;
      4'hA: enc = 7'b1000000;
      default: enc = 7'b0000000;
    endcase
  endfunction

  task automatic push_frame(input logic [31:0] digs);
    logic [3:0] d;
    logic       dp;
    for (int i = 0; i < 8; i++) begin
      d  = digs[4*i +: 4];
      dp = (i == 2) || (i == 4) || (i == 6);
      q.push_back({8'(1 << i), dp, enc(d)});
    end
  endtask

  // Monitor: each new slot (an changes to a nonzero value) pops one entry.
  initial begin
    logic [15:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (an != last_an && an != 8'h00 && q.size() > 0) begin
        exp = q.pop_front();
        total++;
        if ({an, seg} !== exp) begin
          bad++;
          $display("FAIL slot: an=%h seg=%h expected an=%h seg=%h", an, seg, exp[15:8], exp[7:0]);
        end
      end
      last_an = an;
    end
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check8("reset_an", an, 8'h00);
    check8("reset_seg", seg, 8'h00);
    rst = 1'b0;
  endtask

  task automatic wait_an(input logic [7:0] v);
    int n = 0;
    while (an !== v && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (an !== v) begin
      total++;
      bad++;
      $display("FAIL wait_an: got %h expected %h", an, v);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 300) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;

    // Basic frame 12:34:56.78 and release-to-first-slot latency.
    hh = 8'd12; mm = 8'd34; ss = 8'd56; xx = 8'd78;
    do_reset();
    push_frame(32'h1234_5678);
    cnt = 0;
    while (an !== 8'h01 && cnt < 50) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    total++;
    if (cnt != 11) begin
      bad++;
      $display("FAIL latency: got %0d cycles expected 11", cnt);
    end
    drain();

    // Mid-frame input change: current frame keeps 45, next frame shows 46.
    xx = 8'd45;
    do_reset();
    push_frame(32'h1234_5645);
    push_frame(32'h1234_5646);
    wait_an(8'h08);
    xx = 8'd46;
    drain();

    // Out-of-range seconds and hours show dashes.
    hh = 8'd100; mm = 8'd34; ss = 8'd60; xx = 8'd78;
    do_reset();
    push_frame(32'hAA34_AA78);
    drain();

    // All zero, no blanking.
    hh = 8'd0; mm = 8'd0; ss = 8'd0; xx = 8'd0;
    do_reset();
    push_frame(32'h0000_0000);
    drain();

    // Field maxima.
    hh = 8'd99; mm = 8'd59; ss = 8'd59; xx = 8'd99;
    do_reset();
    push_frame(32'h9959_5999);
    drain();

    // Reset at index 5, new values captured in a fresh frame.
    hh = 8'd12; mm = 8'd34; ss = 8'd56; xx = 8'd78;
    do_reset();
    wait_an(8'h20);
    @(negedge clk);
    rst = 1'b1;
    hh = 8'd21; mm = 8'd43; ss = 8'd5; xx = 8'd9;
    @(posedge clk);
    #1;
    check8("midrst_an", an, 8'h00);
    check8("midrst_seg", seg, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    push_frame(32'h2143_0509);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
